// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int PC_STEP    = 4;
  localparam logic [FETCH_XLEN-1:0] RESET_PC_DEF = '0;

  // Default-width {pc, instr} pair held in the fetch buffer.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode handshake: head entry, valid/ready and buffer occupancy.
// Latency: n/a (wires only).
// Backpressure: decode deasserts fetch_ready to hold the head entry.
// Ports (master = fetch side): fetch_valid, fetch_pc, fetch_instr, fetch_count out; fetch_ready in.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = cnt_w(DEPTH);

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_instr;
  logic [CW-1:0]   fetch_count;

  modport master (
    output fetch_valid, fetch_pc, fetch_instr, fetch_count,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr, fetch_count,
    output fetch_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries with synchronous flush and explicit occupancy count.
// Latency: a write is visible at the head on the next cycle when the FIFO was empty.
// Backpressure: push is dropped when full unless the same cycle pops; pop when empty is ignored.
// Ports: clk, reset_n, push_i, pop_i, flush_i, wdata_i in; head_o, count_o, full_o, empty_o out.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  entry_t                    wdata_i,
  output entry_t                    head_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Guard locally so the FIFO can never over/underflow whatever the caller does.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem one word per cycle, queues {pc, instr} for decode.
// Latency: word accepted at edge N is at the buffer head after edge N (1 cycle) when empty.
// Backpressure: stalls PC on full buffer (unless popping) or imem wait; redirect flushes and wins.
// Ports: clk, reset_n, redirect_i, redirect_pc_i, imem_data_i, imem_ready_i in; imem_addr_o out;
//        dec (fetch_if.master) carries the decode handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [XLEN-1:0]    imem_data_i,
  input  logic               imem_ready_i,
  fetch_if.master            dec
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  entry_t          wr_entry;
  entry_t          head;

  // Redirect suppresses both sides so the flush edge starts from a clean, empty buffer.
  assign pop  = ~empty & dec.fetch_ready & ~redirect_i;
  assign push = imem_ready_i & (~full | pop) & ~redirect_i;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~XLEN'(3);
    end else if (push) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr_o    = pc_q[IMEM_AW+1:2];
  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = imem_data_i;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i (wr_entry),
    .head_o  (head),
    .count_o (dec.fetch_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Decode sees buffer registers only; nothing here depends on imem_data_i combinationally.
  assign dec.fetch_valid = ~empty;
  assign dec.fetch_pc    = head.pc;
  assign dec.fetch_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, per-cycle compare, directed scenarios + random run.
// Latency: n/a.
// Backpressure: randomized fetch_ready / imem_ready / redirect.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int IMEM_AW = 10;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic                redirect = 1'b0;
  logic [XLEN-1:0]     redirect_pc = '0;
  logic                imem_ready = 1'b0;
  logic                fetch_ready = 1'b0;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [XLEN-1:0]     imem_data;
  logic [XLEN-1:0]     mem [1024];

  fetch_if #(.XLEN(XLEN), .DEPTH(DEPTH)) dec ();
  assign dec.fetch_ready = fetch_ready;
  assign imem_data       = mem[imem_addr];

  fetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC('0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .imem_ready_i  (imem_ready),
    .dec           (dec)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: buffer contents as a queue plus the next fetch address.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc = '0;

  bit          s4_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] s4_addr[5] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
  bit          s4_vld [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] s4_pc  [5] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = '0;
  endtask

  // One clock edge of the reference: decode takes the head if offered, fetch appends
  // the word at the model PC when memory is ready and room exists (counting the pop).
  task automatic model_step();
    bit do_pop;
    bit do_push;
    do_pop  = (mq.size() != 0) && fetch_ready && !redirect;
    do_push = imem_ready && ((mq.size() < DEPTH) || do_pop) && !redirect;
    if (redirect) begin
      mq.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: m_pc, instr: mem[m_pc[11:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("valid", 32'(dec.fetch_valid), 32'(mq.size() != 0));
      check("count", 32'(dec.fetch_count), 32'(mq.size()));
      check("imem_addr", 32'(imem_addr), 32'(m_pc[11:2]));
      if (mq.size() != 0) begin
        check("head_pc", dec.fetch_pc, mq[0].pc);
        check("head_instr", dec.fetch_instr, mq[0].instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 16);
    #1;
    fetch_ready = 1'b1;
    imem_ready  = 1'b1;
    do_reset();
    chk_en = 1'b1;

    // Reset state
    check("rst_valid", 32'(dec.fetch_valid), 32'd0);
    check("rst_count", 32'(dec.fetch_count), 32'd0);
    check("rst_pc", dec.fetch_pc, 32'h0);
    check("rst_instr", dec.fetch_instr, 32'h0);
    check("rst_addr", 32'(imem_addr), 32'd0);

    // Streaming: one head per cycle, first valid one cycle after release
    tick();
    check("s1_valid", 32'(dec.fetch_valid), 32'd1);
    check("s1_pc0", dec.fetch_pc, 32'h0);
    check("s1_instr0", dec.fetch_instr, 32'h0);
    tick();
    check("s1_pc1", dec.fetch_pc, 32'h4);
    check("s1_instr1", dec.fetch_instr, 32'h10);
    tick();
    check("s1_pc2", dec.fetch_pc, 32'h8);
    check("s1_instr2", dec.fetch_instr, 32'h20);
    check("s1_count", 32'(dec.fetch_count), 32'd1);

    // Fill to full, then pop+push on the same edge
    fetch_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    check("s2_full_count", 32'(dec.fetch_count), 32'd4);
    check("s2_stall_addr", 32'(imem_addr), 32'd4);
    check("s2_head", dec.fetch_pc, 32'h0);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check("s2_pp_count", 32'(dec.fetch_count), 32'd4);
    check("s2_pp_head", dec.fetch_pc, 32'h4);
    check("s2_pp_addr", 32'(imem_addr), 32'd5);

    // Redirect with three buffered entries
    do_reset();
    repeat (3) tick();
    check("s3_count3", 32'(dec.fetch_count), 32'd3);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    check("s3_valid", 32'(dec.fetch_valid), 32'd0);
    check("s3_count", 32'(dec.fetch_count), 32'd0);
    check("s3_addr", 32'(imem_addr), 32'h80);
    tick();
    check("s3_head_pc", dec.fetch_pc, 32'h200);
    check("s3_head_instr", dec.fetch_instr, 32'h800);

    // Memory wait cycles
    fetch_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      imem_ready = s4_rdy[i];
      check("s4_addr", 32'(imem_addr), s4_addr[i]);
      tick();
      check("s4_valid", 32'(dec.fetch_valid), 32'(s4_vld[i]));
      if (s4_vld[i]) check("s4_pc", dec.fetch_pc, s4_pc[i]);
    end

    // PC wrap
    fetch_ready = 1'b0;
    imem_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    check("s5_count", 32'(dec.fetch_count), 32'd2);
    check("s5_head_pc", dec.fetch_pc, 32'hFFFF_FFFC);
    check("s5_head_instr", dec.fetch_instr, 32'h3FF0);
    check("s5_addr", 32'(imem_addr), 32'd1);
    fetch_ready = 1'b1;
    tick();
    check("s5_wrap_pc", dec.fetch_pc, 32'h0);
    check("s5_wrap_instr", dec.fetch_instr, 32'h0);

    // Asynchronous reset with a full buffer
    fetch_ready = 1'b0;
    repeat (5) tick();
    check("s6_pre_count", 32'(dec.fetch_count), 32'd4);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("s6_async_valid", 32'(dec.fetch_valid), 32'd0);
    check("s6_async_count", 32'(dec.fetch_count), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    check("s6_rel_addr", 32'(imem_addr), 32'd0);
    check("s6_rel_pc", dec.fetch_pc, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int c = 0; c < 2000; c++) begin
      imem_ready  = ($urandom_range(0, 9) < 7);
      fetch_ready = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
